// File: rtl/stack_exec_unit.sv
// Operand-stack execution unit: bounded stack, ALU, sticky fault, valid/ready ops.
// Define STACK_MUL_EN to build the iterative W-cycle shift-add multiplier for opcode 15.
module stack_exec_unit #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int DW    = $clog2(DEPTH+1)
) (
  input  logic          eo3,
  input  logic          nF3,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [3:0]    op_code,
  input  logic [W-1:0]  op_imm,
  output logic          rsp_valid,
  output logic [W-1:0]  tos,
  output logic [W-1:0]  nos,
  output logic          zero,
  output logic [DW-1:0] depth,
  output logic          empty,
  output logic          full,
  output logic          fault,
  output logic [1:0]    fault_code
);

  localparam int AW = $clog2(DEPTH);

`ifdef STACK_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  localparam logic [3:0] OpPush = 4'd1;
  localparam logic [3:0] OpPop  = 4'd2;
  localparam logic [3:0] OpDup  = 4'd3;
  localparam logic [3:0] OpSwap = 4'd4;
  localparam logic [3:0] OpOver = 4'd5;
  localparam logic [3:0] OpClrf = 4'd6;
  localparam logic [3:0] OpIll  = 4'd7;
  localparam logic [3:0] OpAdd  = 4'd8;
  localparam logic [3:0] OpSub  = 4'd9;
  localparam logic [3:0] OpXor  = 4'd10;
  localparam logic [3:0] OpAnd  = 4'd11;
  localparam logic [3:0] OpOr   = 4'd12;
  localparam logic [3:0] OpShl  = 4'd13;
  localparam logic [3:0] OpShr  = 4'd14;
  localparam logic [3:0] OpMul  = 4'd15;

  typedef enum logic [1:0] {
    StRun,
    StMul,
    StFault
  } state_t;

  state_t state;

  logic [W-1:0] mem [DEPTH];

  logic [AW-1:0] tIdx, nIdx, pIdx;
  logic [W-1:0]  z, o, alu;
  logic          accept;
  logic          isPush, isPop, isDup, isSwap, isOver, isClrf;
  logic          isBin, isMul, needOne, needTwo, needRoom;
  logic          illegal, under, over, bad;
  logic [1:0]    badCode;
  logic [DW-1:0] depthNext;
  logic          runOk;

  logic          wrEn0, wrEn1;
  logic [AW-1:0] wrIdx0, wrIdx1;
  logic [W-1:0]  wrDat0, wrDat1;

  assign tIdx = AW'(depth - DW'(1));
  assign nIdx = AW'(depth - DW'(2));
  assign pIdx = AW'(depth);
  assign z    = mem[tIdx];
  assign o    = mem[nIdx];

  assign tos   = (depth != '0) ? z : '0;
  assign nos   = (depth >= DW'(2)) ? o : '0;
  assign empty = (depth == '0);
  assign full  = (depth == DW'(DEPTH));

  assign op_ready = (state != StMul);
  assign accept   = op_valid & op_ready;

  assign isPush = (op_code == OpPush);
  assign isPop  = (op_code == OpPop);
  assign isDup  = (op_code == OpDup);
  assign isSwap = (op_code == OpSwap);
  assign isOver = (op_code == OpOver);
  assign isClrf = (op_code == OpClrf);
  assign isBin  = op_code[3] & (op_code != OpMul);
  assign isMul  = MulEn & (op_code == OpMul);

  assign needOne  = isPop | isDup;
  assign needTwo  = isSwap | isOver | isBin | isMul;
  assign needRoom = isPush | isDup | isOver;

  assign illegal = (op_code == OpIll) | ((op_code == OpMul) & !MulEn);
  assign under   = (needOne & (depth == '0))
                 | (needTwo & (depth < DW'(2)));
  assign over    = needRoom & full;
  assign bad     = illegal | under | over;
  assign badCode = illegal ? 2'd3 : (under ? 2'd1 : 2'd2);
  assign runOk   = accept & (state == StRun) & !bad;

  always_comb begin
    alu = '0;
    case (op_code)
      OpAdd: alu = z + o;
      OpSub: alu = z - o;
      OpXor: alu = z ^ o;
      OpAnd: alu = z & o;
      OpOr:  alu = z | o;
      OpShl: alu = (32'(o) >= 32'(W)) ? '0 : (z << o);
      OpShr: alu = (32'(o) >= 32'(W)) ? '0 : (z >> o);
      default: alu = '0;
    endcase
  end

  always_comb begin
    depthNext = depth;
    unique case (1'b1)
      isPush, isDup, isOver: depthNext = depth + DW'(1);
      isPop, isBin:          depthNext = depth - DW'(1);
      default:               depthNext = depth;
    endcase
  end

`ifdef STACK_MUL_EN
  logic [W-1:0] mulA, mulB, mulAcc, accNext;
  logic [5:0]   mulCnt;
  logic         mulLast;

  assign accNext = mulAcc + (mulB[0] ? mulA : '0);
  assign mulLast = (mulCnt == 6'(W-1));
`endif

  always_comb begin
    wrEn0  = 1'b0;
    wrEn1  = 1'b0;
    wrIdx0 = '0;
    wrIdx1 = '0;
    wrDat0 = '0;
    wrDat1 = '0;
    if (runOk) begin
      unique case (1'b1)
        isPush: begin
          wrEn0 = 1'b1; wrIdx0 = pIdx; wrDat0 = op_imm;
        end
        isDup: begin
          wrEn0 = 1'b1; wrIdx0 = pIdx; wrDat0 = z;
        end
        isOver: begin
          wrEn0 = 1'b1; wrIdx0 = pIdx; wrDat0 = o;
        end
        isSwap: begin
          wrEn0 = 1'b1; wrIdx0 = tIdx; wrDat0 = o;
          wrEn1 = 1'b1; wrIdx1 = nIdx; wrDat1 = z;
        end
        isBin: begin
          wrEn0 = 1'b1; wrIdx0 = nIdx; wrDat0 = alu;
        end
        default: ;
      endcase
    end
`ifdef STACK_MUL_EN
    if (state == StMul && mulLast) begin
      wrEn0 = 1'b1; wrIdx0 = nIdx; wrDat0 = accNext;
    end
`endif
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge eo3) begin
    if (wrEn0) mem[wrIdx0] <= wrDat0;
    if (wrEn1) mem[wrIdx1] <= wrDat1;
  end

  always_ff @(posedge eo3) begin
    if (nF3) begin
      state      <= StRun;
      depth      <= '0;
      fault      <= 1'b0;
      fault_code <= 2'd0;
      rsp_valid  <= 1'b0;
      zero       <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        StRun: begin
          if (accept) begin
            if (bad) begin
              fault      <= 1'b1;
              fault_code <= badCode;
              state      <= StFault;
              rsp_valid  <= 1'b1;
            end else if (isMul) begin
              state <= StMul;
            end else begin
              rsp_valid <= 1'b1;
              depth     <= depthNext;
              if (isBin) zero <= (alu == '0);
            end
          end
        end
        StMul: begin
`ifdef STACK_MUL_EN
          if (mulLast) begin
            state     <= StRun;
            depth     <= depth - DW'(1);
            zero      <= (accNext == '0);
            rsp_valid <= 1'b1;
          end
`else
          state <= StRun;
`endif
        end
        StFault: begin
          if (accept) begin
            rsp_valid <= 1'b1;
            if (isClrf) begin
              fault      <= 1'b0;
              fault_code <= 2'd0;
              state      <= StRun;
            end
          end
        end
        default: state <= StRun;
      endcase
    end
  end

`ifdef STACK_MUL_EN
  always_ff @(posedge eo3) begin
    if (nF3) begin
      mulA   <= '0;
      mulB   <= '0;
      mulAcc <= '0;
      mulCnt <= '0;
    end else if (runOk && isMul) begin
      mulA   <= z;
      mulB   <= o;
      mulAcc <= '0;
      mulCnt <= '0;
    end else if (state == StMul) begin
      mulAcc <= accNext;
      mulA   <= mulA << 1;
      mulB   <= mulB >> 1;
      mulCnt <= mulCnt + 6'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stack_exec_unit.sv
// Directed bench for stack_exec_unit at W=8, DEPTH=4.
// Covers both builds; the multiplier section follows STACK_MUL_EN.
module tb_stack_exec_unit;

  logic       eo3 = 1'b0;
  logic       nF3 = 1'b1;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [3:0] op_code = 4'd0;
  logic [7:0] op_imm = 8'd0;
  logic       rsp_valid;
  logic [7:0] tos, nos;
  logic       zero;
  logic [2:0] depth;
  logic       empty, full, fault;
  logic [1:0] fault_code;

  int nCmp = 0;
  int nBad = 0;

  stack_exec_unit #(.W(8), .DEPTH(4)) dut (
    .eo3(eo3), .nF3(nF3),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_imm(op_imm),
    .rsp_valid(rsp_valid), .tos(tos), .nos(nos),
    .zero(zero), .depth(depth), .empty(empty),
    .full(full), .fault(fault), .fault_code(fault_code)
  );

  always #5 eo3 = ~eo3;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic doOp(input logic [3:0] c, input logic [7:0] imm);
    @(negedge eo3);
    op_valid = 1'b1;
    op_code  = c;
    op_imm   = imm;
    @(posedge eo3);
    #1;
    op_valid = 1'b0;
  endtask

  task automatic doReset();
    @(negedge eo3);
    nF3 = 1'b1;
    repeat (2) @(posedge eo3);
    #1;
    nF3 = 1'b0;
  endtask

  task automatic idle();
    @(posedge eo3);
    #1;
  endtask

  initial begin
    logic sawRsp;
    doReset();
    chk("rst_depth", 32'(depth), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_code", 32'(fault_code), 0);
    chk("rst_rsp", 32'(rsp_valid), 0);
    chk("rst_zero", 32'(zero), 0);
    chk("rst_ready", 32'(op_ready), 1);
    chk("rst_tos", 32'(tos), 0);

    doOp(4'd1, 8'd5);
    chk("push5_rsp", 32'(rsp_valid), 1);
    chk("push5_tos", 32'(tos), 32'h5);
    doOp(4'd1, 8'd3);
    chk("push3_rsp", 32'(rsp_valid), 1);
    chk("push3_nos", 32'(nos), 32'h5);
    doOp(4'd9, 8'd0);
    chk("sub_rsp", 32'(rsp_valid), 1);
    chk("sub_tos", 32'(tos), 32'hFE);
    chk("sub_depth", 32'(depth), 1);
    chk("sub_zero", 32'(zero), 0);
    chk("sub_nos", 32'(nos), 0);
    idle();
    chk("rsp_pulse", 32'(rsp_valid), 0);

    doOp(4'd6, 8'd0);
    chk("clrf_run_rsp", 32'(rsp_valid), 1);
    chk("clrf_run_depth", 32'(depth), 1);
    chk("clrf_run_fault", 32'(fault), 0);
    doOp(4'd2, 8'd0);
    chk("pop_depth", 32'(depth), 0);

    doOp(4'd1, 8'd1);
    doOp(4'd1, 8'd2);
    doOp(4'd1, 8'd3);
    doOp(4'd1, 8'd4);
    chk("fill_full", 32'(full), 1);
    chk("fill_depth", 32'(depth), 4);
    doOp(4'd1, 8'd9);
    chk("ovf_rsp", 32'(rsp_valid), 1);
    chk("ovf_fault", 32'(fault), 1);
    chk("ovf_code", 32'(fault_code), 2);
    chk("ovf_tos", 32'(tos), 32'h4);
    chk("ovf_full", 32'(full), 1);
    chk("ovf_ready", 32'(op_ready), 1);
    doOp(4'd6, 8'd0);
    chk("clr_fault", 32'(fault), 0);
    chk("clr_code", 32'(fault_code), 0);
    chk("clr_depth", 32'(depth), 4);
    chk("clr_tos", 32'(tos), 32'h4);
    chk("clr_nos", 32'(nos), 32'h3);

    repeat (4) doOp(4'd2, 8'd0);
    chk("drain_empty", 32'(empty), 1);
    doOp(4'd2, 8'd0);
    chk("udf_code", 32'(fault_code), 1);
    chk("udf_depth", 32'(depth), 0);
    chk("udf_rsp", 32'(rsp_valid), 1);
    doOp(4'd8, 8'd0);
    chk("flt_add_rsp", 32'(rsp_valid), 1);
    chk("flt_add_code", 32'(fault_code), 1);
    doOp(4'd1, 8'd7);
    chk("flt_push_depth", 32'(depth), 0);
    chk("flt_push_code", 32'(fault_code), 1);
    doOp(4'd6, 8'd0);
    chk("flt_clr", 32'(fault), 0);

    doOp(4'd1, 8'd3);
    doOp(4'd1, 8'h81);
    doOp(4'd13, 8'd0);
    chk("shl_tos", 32'(tos), 32'h08);
    chk("shl_depth", 32'(depth), 1);
    chk("shl_zero", 32'(zero), 0);
    doOp(4'd2, 8'd0);
    doOp(4'd1, 8'd9);
    doOp(4'd1, 8'd1);
    doOp(4'd14, 8'd0);
    chk("shr_tos", 32'(tos), 0);
    chk("shr_zero", 32'(zero), 1);
    chk("shr_depth", 32'(depth), 1);
    doOp(4'd2, 8'd0);

    doOp(4'd1, 8'h3C);
    doOp(4'd1, 8'hC3);
    doOp(4'd10, 8'd0);
    chk("xor_tos", 32'(tos), 32'hFF);
    doOp(4'd1, 8'h0F);
    doOp(4'd11, 8'd0);
    chk("and_tos", 32'(tos), 32'h0F);
    doOp(4'd1, 8'hF0);
    doOp(4'd12, 8'd0);
    chk("or_tos", 32'(tos), 32'hFF);
    doOp(4'd1, 8'h01);
    doOp(4'd8, 8'd0);
    chk("add_wrap_tos", 32'(tos), 0);
    chk("add_wrap_zero", 32'(zero), 1);

    doReset();
    doOp(4'd1, 8'h11);
    doOp(4'd1, 8'h22);
    doOp(4'd4, 8'd0);
    chk("swap_tos", 32'(tos), 32'h11);
    chk("swap_nos", 32'(nos), 32'h22);
    doOp(4'd5, 8'd0);
    chk("over_tos", 32'(tos), 32'h22);
    chk("over_depth", 32'(depth), 3);
    doOp(4'd3, 8'd0);
    chk("dup_nos", 32'(nos), 32'h22);
    chk("dup_depth", 32'(depth), 4);
    doOp(4'd3, 8'd0);
    chk("dup_ovf_code", 32'(fault_code), 2);
    chk("dup_ovf_depth", 32'(depth), 4);

    doReset();
    chk("rst2_fault", 32'(fault), 0);
    doOp(4'd7, 8'd0);
    chk("ill_code", 32'(fault_code), 3);
    doReset();
    doOp(4'd5, 8'd0);
    chk("over_udf_code", 32'(fault_code), 1);

`ifdef STACK_MUL_EN
    doReset();
    doOp(4'd1, 8'd13);
    doOp(4'd1, 8'd11);
    doOp(4'd15, 8'd0);
    op_valid = 1'b1;
    op_code  = 4'd1;
    op_imm   = 8'h55;
    for (int i = 0; i < 8; i++) begin
      chk("mul_busy_ready", 32'(op_ready), 0);
      chk("mul_busy_rsp", 32'(rsp_valid), 0);
      idle();
    end
    op_valid = 1'b0;
    chk("mul_rsp", 32'(rsp_valid), 1);
    chk("mul_ready", 32'(op_ready), 1);
    chk("mul_tos", 32'(tos), 32'h8F);
    chk("mul_depth", 32'(depth), 1);
    chk("mul_zero", 32'(zero), 0);

    doReset();
    doOp(4'd1, 8'd13);
    doOp(4'd1, 8'd11);
    doOp(4'd15, 8'd0);
    repeat (3) idle();
    nF3 = 1'b1;
    idle();
    nF3 = 1'b0;
    chk("mulrst_depth", 32'(depth), 0);
    chk("mulrst_ready", 32'(op_ready), 1);
    sawRsp = rsp_valid;
    repeat (8) begin
      idle();
      sawRsp = sawRsp | rsp_valid;
    end
    chk("mulrst_norsp", 32'(sawRsp), 0);
    chk("mulrst_depth2", 32'(depth), 0);
`else
    doReset();
    doOp(4'd1, 8'd13);
    doOp(4'd1, 8'd11);
    doOp(4'd15, 8'd0);
    chk("mul_ill_code", 32'(fault_code), 3);
    chk("mul_ill_depth", 32'(depth), 2);
    chk("mul_ill_rsp", 32'(rsp_valid), 1);
    sawRsp = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/stack_exec_unit.md
Name: stack_exec_unit

Overview:
- Parametrised operand-stack execution engine for the stack-VM core.
- Generalises the fixed 8-bit, single-pointer stack and its ALU: configurable data width and depth, bounds checking, sticky fault state, and a valid/ready op interface.
- Commands come from the decode stage one op per handshake.
- Exposes top-of-stack (TOS), next-on-stack (NOS), zero flag and depth to the branch/store logic.

Parameters:
- W, 8: data width in bits (4..32).
- DEPTH, 16: stack entries, power of two, 2..256.
- DW, $clog2(DEPTH+1): width of the depth counter (derived, not to be overridden).

Ports:
- eo3  in  1  clock; all logic on the rising edge.
- nF3  in  1  reset, synchronous, active-high.
- op_valid  in  1  op presented.
- op_ready  out  1  unit can accept an op this cycle.
- op_code  in  4  opcode.
- op_imm  in  W  immediate for PUSH.
- rsp_valid  out  1  one-cycle pulse, op retired.
- tos  out  W  top of stack, 0 when empty.
- nos  out  W  second entry, 0 when depth<2.
- zero  out  1  result of last retired ALU op == 0.
- depth  out  DW  current entry count.
- empty  out  1  depth==0.
- full  out  1  depth==DEPTH.
- fault  out  1  sticky fault.
- fault_code  out  2  0 none, 1 underflow, 2 overflow, 3 illegal op.

Behaviour:
- Reset (nF3=1 at edge):
  - depth=0, fault=0, fault_code=0, rsp_valid=0, zero=0, state=RUN.
  - Storage contents are not cleared.
  - Reset overrides everything, including an in-flight MUL.
- States:
  - RUN: op_ready=1.
  - MUL: op_ready=0.
  - FAULT: op_ready=1.
- An op is accepted at an edge with op_valid & op_ready. Single-cycle ops update the stack at that edge; rsp_valid=1 the following cycle.
- Opcodes (Z=TOS, O=NOS):
  - 0 NOP.
  - 1 PUSH imm.
  - 2 POP.
  - 3 DUP.
  - 4 SWAP.
  - 5 OVER (push O).
  - 6 CLRF.
  - 7 illegal.
  - 8 ADD Z+O.
  - 9 SUB Z-O.
  - 10 XOR.
  - 11 AND.
  - 12 OR.
  - 13 SHL Z<<O.
  - 14 SHR Z>>O.
  - 15 MUL.
- Binary ops pop two and push the result: depth-1, result in the new TOS, zero updated.
- Arithmetic is modulo 2^W. For shifts with O>=W the result is 0.
- Required depth per op:
  - PUSH/DUP/OVER need room. PUSH needs depth<DEPTH. DUP needs depth>=1 and depth<DEPTH. OVER needs depth>=2 and depth<DEPTH.
  - POP needs depth>=1. SWAP and binary ops need depth>=2.
- Underflow takes precedence over overflow.
- Violation or illegal op:
  - Stack unchanged; fault=1; fault_code set; state=FAULT.
  - rsp_valid still pulses.
- In FAULT:
  - Every op except CLRF is accepted and discarded: no stack change, rsp_valid pulses, fault_code holds the first cause.
  - CLRF clears fault/fault_code and returns to RUN; the stack is kept.
- CLRF in RUN is a NOP.
- tos, nos, depth, empty and full are registered views, valid in the cycle after the updating edge.
- While op_ready=0 the op inputs are ignored. Decode holds op_valid without penalty.

Optional Feature:
- Macro STACK_MUL_EN.
- Defined:
  - MUL (15) is accepted with depth>=2 and enters state MUL.
  - Iterative shift-add, one bit per cycle, for exactly W cycles.
  - At the final edge: pop two, push the low W bits of Z*O, update zero, return to RUN.
  - rsp_valid pulses in the cycle after, so latency is W+1 cycles from accept to rsp_valid.
  - Underflow is checked at accept; on underflow the unit never enters MUL.
- Not defined: opcode 15 is illegal (fault_code=3) and no multiplier logic is built.

Test Plan:
- Reset, then PUSH 5, PUSH 3, SUB -> tos=0xFE (W=8), depth=1, zero=0; rsp_valid 3 pulses.
- DEPTH=4: PUSH 1..4, PUSH 9 -> full=1, fault=1, fault_code=2, tos=4; then CLRF -> fault=0, depth=4, tos=4.
- Empty stack POP -> fault_code=1, depth=0. Then ADD while in FAULT -> discarded, fault_code stays 1, rsp_valid pulses.
- PUSH 3, PUSH 0x81, SHL (Z=0x81, O=3) -> tos=0x08; PUSH 9, PUSH 1, SHR (O=9>=8) -> tos=0, zero=1.
- With STACK_MUL_EN: PUSH 13, PUSH 11, MUL -> op_ready=0 for 8 cycles, rsp_valid at accept+9, tos=0x8F. Reset asserted at accept+4 -> depth=0, state RUN, no rsp_valid.
- Without STACK_MUL_EN: MUL with depth 2 -> fault_code=3, depth=2.
